jk_bank_sched: RTL and testbench

JK_BANK_SCHED -- requirements
Module: jk_bank_sched

---
 rtl/jk_pkg.sv | 22 ++
 rtl/jk_bank.sv | 21 ++
 rtl/jk_bank_sched.sv | 112 +++++++++++
 tb/tb_jk_bank_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types and defaults for the JK bank scheduler: bit operations,
// scheduler FSM states and default sizing.
package jk_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  // Encoding is {j, k}, so an op can drive a JK bit directly
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH independent JK flip-flops with asynchronous clear to zero.
module jk_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  // Characteristic equation: q+ = j&~q | ~k&q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler granting one requester at a time a JK operation
// on a shared bit bank; each op takes IDLE -> APPLY -> DONE.
module jk_bank_sched
  import jk_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [2*N_REQ-1:0]       req_op,
  input  logic [WIDTH*N_REQ-1:0]   req_mask,
  output logic [N_REQ-1:0]         req_ack,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int IDW = $clog2(N_REQ);

  sched_state_e   state;
  sched_state_e   state_next;
  jk_op_e         op_lat;
  logic [WIDTH-1:0] mask_lat;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           found;
  int             idx;
  logic [WIDTH-1:0] bank_j;
  logic [WIDTH-1:0] bank_k;

  // Search upward from rr_ptr with wrap; the first valid requester wins
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (|req_valid) state_next = ST_APPLY;
      ST_APPLY: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The winner's request is captured so it may drop valid during APPLY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_lat   <= JK_HOLD;
      mask_lat <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      if (state == ST_IDLE && (|req_valid)) begin
        op_lat   <= jk_op_e'(req_op[2*int'(winner) +: 2]);
        mask_lat <= req_mask[WIDTH*int'(winner) +: WIDTH];
        grant_id <= winner;
      end
      if (state == ST_DONE) begin
        rr_ptr <= (grant_id == IDW'(N_REQ-1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  always_comb begin
    bank_j  = '0;
    bank_k  = '0;
    req_ack = '0;
    if (state == ST_APPLY) begin
      bank_j = mask_lat & {WIDTH{op_lat[1]}};
      bank_k = mask_lat & {WIDTH{op_lat[0]}};
    end
    if (state == ST_DONE) begin
      req_ack[grant_id] = 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

  jk_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .j    (bank_j),
    .k    (bank_k),
    .q    (q)
  );

endmodule

// File: tb/tb_jk_bank_sched.sv
// Directed self-checking bench for jk_bank_sched (N_REQ=4, WIDTH=8);
// inputs change and outputs are sampled on the falling clock edge.
module tb_jk_bank_sched;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [2*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_mask;
  logic [N_REQ-1:0]       req_ack;
  logic [WIDTH-1:0]       q;
  logic                   busy;
  logic [1:0]             grant_id;

  int error_count = 0;
  int check_count = 0;
  int order [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  jk_bank_sched #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_mask (req_mask),
    .req_ack  (req_ack),
    .q        (q),
    .busy     (busy),
    .grant_id (grant_id)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic [2*N_REQ-1:0] op,
                               input logic [WIDTH*N_REQ-1:0] mask);
    req_valid = valid;
    req_op    = op;
    req_mask  = mask;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'h0, 8'h00, 32'h0);
    step();
    step();
    checkOutput("rst_q", q, 8'h00);
    checkOutput("rst_ack", req_ack, 4'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant", grant_id, 2'd0);

    // Requester 0 set 0x0F, issued on the cycle reset is released
    rst_n = 1'b1;
    applyStimulus(4'b0001, 8'b0000_0010, 32'h0000_000F);
    step();
    checkOutput("set_apply_busy", busy, 1'b1);
    checkOutput("set_apply_grant", grant_id, 2'd0);
    checkOutput("set_apply_ack", req_ack, 4'h0);
    step();
    checkOutput("set_done_ack", req_ack, 4'b0001);
    checkOutput("set_done_q", q, 8'h0F);
    applyStimulus(4'h0, 8'h00, 32'h0);
    step();
    checkOutput("set_idle_ack", req_ack, 4'h0);
    checkOutput("set_idle_busy", busy, 1'b0);

    // Requester 2 toggles all bits: 0x0F -> 0xF0
    applyStimulus(4'b0100, 8'b0011_0000, 32'h00FF_0000);
    step();
    checkOutput("tgl_grant", grant_id, 2'd2);
    step();
    checkOutput("tgl_ack", req_ack, 4'b0100);
    checkOutput("tgl_q", q, 8'hF0);
    applyStimulus(4'h0, 8'h00, 32'h0);
    step();

    // Requester 3 sets low nibble to reach 0xFF
    applyStimulus(4'b1000, 8'b1000_0000, 32'h0F00_0000);
    step();
    checkOutput("fill_grant", grant_id, 2'd3);
    step();
    checkOutput("fill_ack", req_ack, 4'b1000);
    checkOutput("fill_q", q, 8'hFF);
    applyStimulus(4'h0, 8'h00, 32'h0);
    step();

    // Requester 1 clears bits 7 and 0, then a zero-mask toggle
    applyStimulus(4'b0010, 8'b0000_0100, 32'h0000_8100);
    step();
    checkOutput("clr_grant", grant_id, 2'd1);
    step();
    checkOutput("clr_ack", req_ack, 4'b0010);
    checkOutput("clr_q", q, 8'h7E);
    applyStimulus(4'h0, 8'h00, 32'h0);
    step();
    applyStimulus(4'b0010, 8'b0000_1100, 32'h0000_0000);
    step();
    checkOutput("zero_busy", busy, 1'b1);
    step();
    checkOutput("zero_ack", req_ack, 4'b0010);
    checkOutput("zero_q", q, 8'h7E);
    applyStimulus(4'h0, 8'h00, 32'h0);
    step();

    // Reset to rr_ptr=0, then all requesters valid continuously
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_q", q, 8'h00);
    step();
    rst_n = 1'b1;
    applyStimulus(4'hF, 8'hFF, 32'h0804_0201);
    for (int g = 0; g < 5; g++) begin
      step();
      checkOutput("fair_grant", grant_id, 32'(order[g]));
      checkOutput("fair_apply_ack", req_ack, 4'h0);
      step();
      checkOutput("fair_ack", req_ack, 32'(1) << order[g]);
      step();
      checkOutput("fair_idle_ack", req_ack, 4'h0);
      checkOutput("fair_idle_busy", busy, 1'b0);
    end
    checkOutput("fair_q", q, 8'h0E);
    applyStimulus(4'h0, 8'h00, 32'h0);

    // Reset during APPLY aborts requester 2's set
    applyStimulus(4'b0100, 8'b0010_0000, 32'h00FF_0000);
    step();
    checkOutput("abort_apply_grant", grant_id, 2'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_q", q, 8'h00);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_grant", grant_id, 2'd0);
    applyStimulus(4'h0, 8'h00, 32'h0);
    step();
    checkOutput("abort_hold_ack", req_ack, 4'h0);
    checkOutput("abort_hold_q", q, 8'h00);
    rst_n = 1'b1;
    step();
    checkOutput("abort_no_pending", busy, 1'b0);
    checkOutput("abort_no_ack", req_ack, 4'h0);
    applyStimulus(4'b1001, 8'b0100_0010, 32'hFF00_003C);
    step();
    checkOutput("post_rst_grant", grant_id, 2'd0);
    step();
    checkOutput("post_rst_ack", req_ack, 4'b0001);
    checkOutput("post_rst_q", q, 8'h3C);
    applyStimulus(4'h0, 8'h00, 32'h0);
    step();

    // Requester 1 toggles 0x0F, then drops and scrambles its inputs in APPLY
    applyStimulus(4'b0010, 8'b0000_1100, 32'h0000_0F00);
    step();
    checkOutput("drop_grant", grant_id, 2'd1);
    applyStimulus(4'h0, 8'b0000_0100, 32'h0000_FF00);
    step();
    checkOutput("drop_ack", req_ack, 4'b0010);
    checkOutput("drop_q", q, 8'h33);
    step();
    checkOutput("drop_idle_ack", req_ack, 4'h0);
    step();
    checkOutput("drop_stay_idle", busy, 1'b0);
    checkOutput("drop_final_q", q, 8'h33);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
